// File: rtl/regfile_checker.sv
// End-of-program register-file checker: waits for CPU halt (bounded), scans every
// register through a spare read port and compares against a table of expected values.
module regfile_checker #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int AW      = 5,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 10000,
    parameter int TW      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            halt,
    input  logic            exp_we,
    input  logic [AW-1:0]   exp_addr,
    input  logic [XLEN-1:0] exp_data,
    input  logic            exp_chk,
    output logic [AW-1:0]   rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [AW:0]     err_count,
    output logic [AW-1:0]   first_err_idx,
    output logic [XLEN-1:0] first_err_got
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    state_t state, state_nxt;

    logic [XLEN-1:0] exp_mem [NREGS];
    logic [NREGS-1:0] chk_bits;
    logic [TW-1:0]   wait_cnt;

    logic            start_ok;
    logic            wait_last;
    logic            scan_last;
    logic            enter_done;
    logic            tbl_wr;

    logic            vld_p0;
    logic [AW-1:0]   idx_p0;
    logic            vld_cmp;
    logic [AW-1:0]   idx_cmp;
    logic            mismatch;
    logic [AW:0]     err_nxt;

    function automatic logic is_mismatch(input logic en, input logic [XLEN-1:0] got,
                                         input logic [XLEN-1:0] want);
        return en && (got != want);
    endfunction

    assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
    assign wait_last  = (wait_cnt == WAIT_LAST);
    assign scan_last  = (rf_raddr == LAST_IDX);
    assign enter_done = (state_nxt == S_DONE) && (state != S_DONE);

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_WAIT;
            S_WAIT:         if (halt || wait_last) state_nxt = S_SCAN;
            S_SCAN:         if (scan_last) state_nxt = (RD_LAT == 1) ? S_DRAIN : S_DONE;
            S_DRAIN:        state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_WAIT, S_SCAN, S_DRAIN: busy = 1'b1;
            S_DONE:                  done = 1'b1;
            default: ;
        endcase
    end

    // Expected table: data is never reset, only the enables are, so stale data is harmless.
    assign tbl_wr = exp_we && !busy && ({1'b0, exp_addr} < (AW+1)'(NREGS));

    always_ff @(posedge clk) begin
        if (tbl_wr) exp_mem[exp_addr] <= exp_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      chk_bits <= '0;
        else if (tbl_wr) chk_bits[exp_addr] <= exp_chk;
    end

    // ---- p0: address presented to the register file ----
    assign vld_p0 = (state == S_SCAN);
    assign idx_p0 = rf_raddr;

    // ---- p1: read data returns RD_LAT cycles later ----
    generate
        if (RD_LAT == 1) begin : g_lat1
            logic          vld_p1;
            logic [AW-1:0] idx_p1;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) vld_p1 <= 1'b0;
                else        vld_p1 <= vld_p0;
            end

            always_ff @(posedge clk) begin
                idx_p1 <= idx_p0;
            end

            assign vld_cmp = vld_p1;
            assign idx_cmp = idx_p1;
        end else begin : g_lat0
            assign vld_cmp = vld_p0;
            assign idx_cmp = idx_p0;
        end
    endgenerate

    assign mismatch = is_mismatch(vld_cmp && chk_bits[idx_cmp], rf_rdata, exp_mem[idx_cmp]);
    assign err_nxt  = err_count + (AW+1)'(mismatch);

    // Sequencing and result registers; pass sees the final compare through err_nxt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt      <= '0;
            timeout       <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
            rf_raddr      <= '0;
        end else if (start_ok) begin
            wait_cnt      <= '0;
            timeout       <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
            rf_raddr      <= '0;
        end else begin
            if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
                if (!halt && wait_last) timeout <= 1'b1;
            end

            if (state == S_SCAN) begin
                if (!scan_last)        rf_raddr <= rf_raddr + 1'b1;
                else if (RD_LAT != 1)  rf_raddr <= '0;
            end else if (state == S_DRAIN) begin
                rf_raddr <= '0;
            end

            if (mismatch) begin
                err_count <= err_nxt;
                if (err_count == '0) begin
                    first_err_idx <= idx_cmp;
                    first_err_got <= rf_rdata;
                end
            end

            if (enter_done) pass <= (err_nxt == '0) && !timeout;
        end
    end

endmodule

// File: tb/tb_regfile_checker.sv
// Scoreboard bench: two checkers (RD_LAT=0 with combinational read, RD_LAT=1 with
// registered read) run the same directed scenarios; expected results are queued per run.
module tb_regfile_checker;

    localparam int XLEN    = 32;
    localparam int NREGS   = 32;
    localparam int AW      = 5;
    localparam int TIMEOUT = 50;
    localparam int TW      = 16;

    typedef struct {
        int          err;
        int          fidx;
        logic [31:0] fgot;
        bit          pss;
        bit          tmo;
        int          dcyc;
    } res_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            halt = 1'b0;
    logic            exp_we = 1'b0;
    logic [AW-1:0]   exp_addr = '0;
    logic [XLEN-1:0] exp_data = '0;
    logic            exp_chk = 1'b0;

    logic [XLEN-1:0] rf_model [NREGS];

    logic [AW-1:0]   raddr0, raddr1;
    logic [XLEN-1:0] rdata0, rdata1;
    logic            busy0, busy1, done0, done1, pass0, pass1, tmo0, tmo1;
    logic [AW:0]     ec0, ec1;
    logic [AW-1:0]   fi0, fi1;
    logic [XLEN-1:0] fg0, fg1;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    res_t q0[$];
    res_t q1[$];
    res_t e0, e1;
    logic done0_q = 1'b0;
    logic done1_q = 1'b0;

    regfile_checker #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .RD_LAT(0),
                      .TIMEOUT(TIMEOUT), .TW(TW)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .exp_chk(exp_chk),
        .rf_raddr(raddr0), .rf_rdata(rdata0),
        .busy(busy0), .done(done0), .pass(pass0), .timeout(tmo0),
        .err_count(ec0), .first_err_idx(fi0), .first_err_got(fg0)
    );

    regfile_checker #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .RD_LAT(1),
                      .TIMEOUT(TIMEOUT), .TW(TW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .exp_chk(exp_chk),
        .rf_raddr(raddr1), .rf_rdata(rdata1),
        .busy(busy1), .done(done1), .pass(pass1), .timeout(tmo1),
        .err_count(ec1), .first_err_idx(fi1), .first_err_got(fg1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign rdata0 = rf_model[raddr0];
    always @(posedge clk) rdata1 <= rf_model[raddr1];

    task automatic chk(input string name, input longint got, input longint want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic check_res(input string tag, input res_t e, input logic [AW:0] ec,
                             input logic [AW-1:0] fi, input logic [XLEN-1:0] fg,
                             input logic ps, input logic tm);
        chk({tag, " err_count"}, ec, e.err);
        chk({tag, " first_err_idx"}, fi, e.fidx);
        chk({tag, " first_err_got"}, fg, e.fgot);
        chk({tag, " pass"}, ps, e.pss);
        chk({tag, " timeout"}, tm, e.tmo);
        chk({tag, " done_cycle"}, cyc, e.dcyc);
    endtask

    // Monitors: pop on each rising done.
    always @(negedge clk) begin
        done0_q <= done0;
        if (rst_n && done0 && !done0_q) begin
            if (q0.size() == 0) chk("dut0 unexpected_done", 1, 0);
            else begin
                e0 = q0.pop_front();
                check_res("dut0", e0, ec0, fi0, fg0, pass0, tmo0);
            end
        end
    end

    always @(negedge clk) begin
        done1_q <= done1;
        if (rst_n && done1 && !done1_q) begin
            if (q1.size() == 0) chk("dut1 unexpected_done", 1, 0);
            else begin
                e1 = q1.pop_front();
                check_res("dut1", e1, ec1, fi1, fg1, pass1, tmo1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [31:0] d, input logic c);
        exp_addr = AW'(a);
        exp_data = d;
        exp_chk  = c;
        exp_we   = 1'b1;
        tick();
        exp_we   = 1'b0;
    endtask

    task automatic rf_base();
        for (int i = 0; i < NREGS; i++) rf_model[i] = 32'hA5A5_0000 | i;
        rf_model[8]  = 1;
        rf_model[9]  = 2;
        rf_model[18] = 3;
        rf_model[19] = 4;
        rf_model[20] = 5;
        rf_model[21] = 6;
    endtask

    task automatic do_start(output int wf);
        start = 1'b1;
        tick();
        start = 1'b0;
        wf = cyc;
    endtask

    task automatic push_exp(input int s, input int err, input int fidx,
                            input logic [31:0] fgot, input bit pss, input bit tmo);
        res_t e;
        e.err  = err;
        e.fidx = fidx;
        e.fgot = fgot;
        e.pss  = pss;
        e.tmo  = tmo;
        e.dcyc = s + NREGS;
        q0.push_back(e);
        e.dcyc = s + NREGS + 1;
        q1.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(done0 && done1) && n < 150) begin
            tick();
            n++;
        end
        if (!(done0 && done1)) chk("wait_done bound", 0, 1);
        halt = 1'b0;
        tick();
    endtask

    function automatic longint outs0();
        return {busy0, done0, pass0, tmo0, ec0, fi0, fg0, raddr0};
    endfunction

    function automatic longint outs1();
        return {busy1, done1, pass1, tmo1, ec1, fi1, fg1, raddr1};
    endfunction

    initial begin
        int wf;
        int s;
        rf_base();
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("dut0 reset outputs", outs0(), 0);
        chk("dut1 reset outputs", outs1(), 0);

        load(8, 1, 1);
        load(9, 2, 1);
        load(18, 3, 1);
        load(19, 4, 1);
        load(20, 5, 1);
        load(21, 6, 1);

        // matching register file, halt three cycles into WAIT
        do_start(wf);
        tick(); tick(); tick();
        halt = 1'b1;
        s = cyc + 1;
        push_exp(s, 0, 0, 0, 1, 0);
        wait_done();

        // two mismatches
        rf_model[19] = 7;
        rf_model[21] = 0;
        do_start(wf);
        tick();
        halt = 1'b1;
        s = cyc + 1;
        push_exp(s, 2, 19, 7, 0, 0);
        wait_done();

        // halt never arrives
        do_start(wf);
        push_exp(wf + TIMEOUT, 2, 19, 7, 0, 1);
        wait_done();

        // halt in the same cycle the counter reaches TIMEOUT-1
        rf_model[19] = 4;
        rf_model[21] = 6;
        do_start(wf);
        while (cyc < wf + TIMEOUT - 1) tick();
        halt = 1'b1;
        push_exp(wf + TIMEOUT, 0, 0, 0, 1, 0);
        wait_done();

        // start and exp_we during SCAN must be ignored
        rf_model[19] = 7;
        rf_model[21] = 0;
        do_start(wf);
        tick();
        halt = 1'b1;
        s = cyc + 1;
        push_exp(s, 2, 19, 7, 0, 0);
        while (cyc < s + 2) tick();
        start = 1'b1;
        load(19, 7, 1);
        start = 1'b0;
        chk("busy after start in scan", {busy0, busy1}, 2'b11);
        wait_done();

        do_start(wf);
        halt = 1'b1;
        s = cyc + 1;
        push_exp(s, 2, 19, 7, 0, 0);
        wait_done();

        // asynchronous reset in the middle of SCAN
        do_start(wf);
        halt = 1'b1;
        s = cyc + 1;
        while (cyc < s + 5) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("dut0 async reset outputs", outs0(), 0);
        chk("dut1 async reset outputs", outs1(), 0);
        halt = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        do_start(wf);
        halt = 1'b1;
        s = cyc + 1;
        push_exp(s, 0, 0, 0, 1, 0);
        wait_done();

        // first and last register checked
        rf_model[0]  = 32'h77;
        rf_model[31] = 32'h1234;
        load(0, 5, 1);
        load(31, 32'h31, 1);
        do_start(wf);
        halt = 1'b1;
        s = cyc + 1;
        push_exp(s, 2, 0, 32'h77, 0, 0);
        wait_done();

        tick();
        chk("dut0 queue drained", q0.size(), 0);
        chk("dut1 queue drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
